pcie_tx_cpl_bfm: RTL and testbench

Testbench completer BFM for the client transmit side of the PCIe endpoint model.
- Pops memory-read request headers and their lookup IDs, both queued by the target-receive BFM.
- Builds CplD (or UR Cpl) TLPs and drives them onto the client0 transmit interface, honouring `xadm_client0_halt_i` backpressure.
- Payload is a deterministic address-derived pattern, so the host-side checker can verify every returned DW.

---
 rtl/pcie_tx_cpl_bfm.sv | 224 ++++++++++++++++++++++
 tb/tb_pcie_tx_cpl_bfm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_cpl_bfm.sv
// Completer BFM for the client0 transmit side: pops MRd headers plus lookup IDs and answers
// each with a CplD carrying an address-derived payload, or a UR Cpl when the read is too long.
//   state   | meaning
//   S_IDLE  | waiting for a queued request header
//   S_FETCH | pop header FIFO and lookup-ID RAM (data valid next cycle)
//   S_LOAD  | decode header; drop non-MRd, else build the first beat
//   S_SEND  | drive beats, advancing only on accepted beats; IDLE after accepted eot
module pcie_tx_cpl_bfm #(
  parameter int MAX_PLD_DW = 256,
  parameter int DT_WD      = 128,
  parameter int HDR_WD     = 128
) (
  input  logic              core_clk,
  input  logic              core_rst,
  output logic              mrd_rden_o,
  input  logic [HDR_WD-1:0] mrd_q_i,
  input  logic              mrd_rdempty_i,
  output logic              trgtlookup_id_rden_o,
  input  logic [9:0]        trgtlookup_id_i,
  input  logic [15:0]       cpl_id_i,
  output logic              client0_tlp_hv_o,
  output logic              client0_tlp_dv_o,
  output logic              client0_tlp_eot_o,
  output logic [DT_WD-1:0]  client0_tlp_data_o,
  output logic [3:0]        client0_tlp_dwen_o,
  output logic [1:0]        client0_tlp_fmt_o,
  output logic [4:0]        client0_tlp_type_o,
  output logic [2:0]        client0_tlp_tc_o,
  output logic [1:0]        client0_tlp_attr_o,
  output logic [12:0]       client0_tlp_byte_len_o,
  output logic [2:0]        client0_cpl_status_o,
  output logic [11:0]       client0_cpl_byte_cnt_o,
  output logic [6:0]        client0_cpl_low_addr_o,
  output logic [9:0]        client0_cpl_lookup_id_o,
  output logic [15:0]       client0_req_id_o,
  output logic [15:0]       client0_cpl_id_o,
  input  logic              xadm_client0_halt_i,
  output logic [31:0]       cpl_cnt_o,
  output logic [15:0]       ur_cnt_o,
  output logic [15:0]       drop_cnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND} state_t;

  state_t r_state, w_state_nxt;
  logic w_fetch, w_accept;

  logic r_hv, r_dv, r_eot, r_ur;
  logic [DT_WD-1:0] r_data;
  logic [3:0]  r_dwen, r_last_dwen;
  logic [1:0]  r_fmt, r_attr;
  logic [4:0]  r_type;
  logic [2:0]  r_tc, r_status;
  logic [12:0] r_byte_len;
  logic [11:0] r_bc;
  logic [6:0]  r_low;
  logic [9:0]  r_lid;
  logic [15:0] r_rid, r_cid;
  logic [8:0]  r_beat_rem;
  logic [31:0] r_dw_addr;
  logic [31:0] r_cpl_cnt;
  logic [15:0] r_ur_cnt, r_drop_cnt;

  logic [31:0] w_dw0, w_dw1, w_addr, w_base;
  logic [3:0]  w_fbe, w_lbe, w_last_dwen;
  logic [10:0] w_len, w_len_m1;
  logic [8:0]  w_beats_m1;
  logic [1:0]  w_fbe_off, w_fbe_top;
  logic [2:0]  w_lbe_trim;
  logic [12:0] w_bc13;
  logic        w_is_mrd, w_ur;
  logic        w_unused_bits;

  assign w_dw0      = mrd_q_i[31:0];
  assign w_dw1      = mrd_q_i[63:32];
  assign w_addr     = w_dw0[29] ? mrd_q_i[127:96] : mrd_q_i[95:64];
  assign w_base     = {w_addr[31:2], 2'b00};
  assign w_fbe      = w_dw1[3:0];
  assign w_lbe      = w_dw1[7:4];
  assign w_is_mrd   = !w_dw0[30] && (w_dw0[28:24] == 5'd0);
  assign w_len      = (w_dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, w_dw0[9:0]};
  assign w_len_m1   = w_len - 11'd1;
  assign w_beats_m1 = w_len_m1[10:2];
  assign w_ur       = (w_len > 11'(MAX_PLD_DW));

  assign w_unused_bits = ^{w_dw0[31], w_dw0[23], w_dw0[19:14], w_dw0[11:10], w_dw1[15:8],
                           w_addr[1:0], w_len_m1[1:0], w_bc13[12]};

  always_comb begin
    w_fbe_off = 2'd0;
    if (w_fbe[0])      w_fbe_off = 2'd0;
    else if (w_fbe[1]) w_fbe_off = 2'd1;
    else if (w_fbe[2]) w_fbe_off = 2'd2;
    else if (w_fbe[3]) w_fbe_off = 2'd3;
    w_fbe_top = 2'd0;
    if (w_fbe[3])      w_fbe_top = 2'd3;
    else if (w_fbe[2]) w_fbe_top = 2'd2;
    else if (w_fbe[1]) w_fbe_top = 2'd1;
    w_lbe_trim = 3'd4;
    if (w_lbe[3])      w_lbe_trim = 3'd0;
    else if (w_lbe[2]) w_lbe_trim = 3'd1;
    else if (w_lbe[1]) w_lbe_trim = 3'd2;
    else if (w_lbe[0]) w_lbe_trim = 3'd3;
    case (w_len[1:0])
      2'd1:    w_last_dwen = 4'b0001;
      2'd2:    w_last_dwen = 4'b0011;
      2'd3:    w_last_dwen = 4'b0111;
      default: w_last_dwen = 4'b1111;
    endcase
    // a single-DW read counts only the bytes spanned by the first BE
    if (w_ur)                 w_bc13 = 13'd0;
    else if (w_len == 11'd1)  w_bc13 = (w_fbe == 4'd0) ? 13'd1 : 13'(w_fbe_top - w_fbe_off) + 13'd1;
    else                      w_bc13 = {w_len, 2'b00} - 13'(w_fbe_off) - 13'(w_lbe_trim);
  end

  function automatic logic [DT_WD-1:0] f_beat(input logic [31:0] a);
    logic [DT_WD-1:0] d;
    d = '0;
    for (int k = 0; k < DT_WD/32; k++) d[k*32 +: 32] = a + 32'(4*k);
    return d;
  endfunction

  always_ff @(posedge core_clk) begin
    if (core_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:  if (!mrd_rdempty_i) w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD:  w_state_nxt = w_is_mrd ? S_SEND : S_IDLE;
      S_SEND: begin
        w_accept = (r_hv | r_dv | r_eot) & ~xadm_client0_halt_i;
        if (w_accept && r_eot) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst || (w_accept && r_eot)) begin
      r_hv <= 1'b0;  r_dv <= 1'b0;  r_eot <= 1'b0;  r_ur <= 1'b0;
      r_data <= '0;  r_dwen <= 4'd0;  r_last_dwen <= 4'd0;
      r_fmt <= 2'd0; r_type <= 5'd0;  r_tc <= 3'd0;  r_attr <= 2'd0;
      r_byte_len <= 13'd0; r_status <= 3'd0; r_bc <= 12'd0; r_low <= 7'd0;
      r_lid <= 10'd0; r_rid <= 16'd0; r_cid <= 16'd0;
      r_beat_rem <= 9'd0; r_dw_addr <= 32'd0;
    end else if (r_state == S_LOAD && w_is_mrd) begin
      r_hv        <= 1'b1;
      r_dv        <= !w_ur;
      r_eot       <= w_ur || (w_beats_m1 == 9'd0);
      r_ur        <= w_ur;
      r_data      <= w_ur ? '0 : f_beat(w_base);
      r_dwen      <= w_ur ? 4'd0 : ((w_beats_m1 == 9'd0) ? w_last_dwen : 4'b1111);
      r_last_dwen <= w_last_dwen;
      r_fmt       <= w_ur ? 2'b00 : 2'b10;
      r_type      <= 5'b01010;
      r_tc        <= w_dw0[22:20];
      r_attr      <= w_dw0[13:12];
      r_byte_len  <= w_ur ? 13'd0 : {w_len, 2'b00};
      r_status    <= w_ur ? 3'b001 : 3'b000;
      r_bc        <= w_bc13[11:0];
      r_low       <= {w_addr[6:2], w_fbe_off};
      r_lid       <= trgtlookup_id_i;
      r_rid       <= w_dw1[31:16];
      r_cid       <= cpl_id_i;
      r_beat_rem  <= w_ur ? 9'd0 : w_beats_m1;
      r_dw_addr   <= w_base;
    end else if (w_accept) begin
      r_hv       <= 1'b0;
      r_beat_rem <= r_beat_rem - 9'd1;
      r_dw_addr  <= r_dw_addr + 32'd16;
      r_data     <= f_beat(r_dw_addr + 32'd16);
      r_eot      <= (r_beat_rem == 9'd1);
      r_dwen     <= (r_beat_rem == 9'd1) ? r_last_dwen : 4'b1111;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_cpl_cnt  <= 32'd0;
      r_ur_cnt   <= 16'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (r_state == S_LOAD && !w_is_mrd) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_accept && r_eot) begin
        r_cpl_cnt <= r_cpl_cnt + 32'd1;
        if (r_ur) r_ur_cnt <= r_ur_cnt + 16'd1;
      end
    end
  end

  assign mrd_rden_o              = w_fetch;
  assign trgtlookup_id_rden_o    = w_fetch;
  assign busy_o                  = (r_state != S_IDLE);
  assign client0_tlp_hv_o        = r_hv;
  assign client0_tlp_dv_o        = r_dv;
  assign client0_tlp_eot_o       = r_eot;
  assign client0_tlp_data_o      = r_data;
  assign client0_tlp_dwen_o      = r_dwen;
  assign client0_tlp_fmt_o       = r_fmt;
  assign client0_tlp_type_o      = r_type;
  assign client0_tlp_tc_o        = r_tc;
  assign client0_tlp_attr_o      = r_attr;
  assign client0_tlp_byte_len_o  = r_byte_len;
  assign client0_cpl_status_o    = r_status;
  assign client0_cpl_byte_cnt_o  = r_bc;
  assign client0_cpl_low_addr_o  = r_low;
  assign client0_cpl_lookup_id_o = r_lid;
  assign client0_req_id_o        = r_rid;
  assign client0_cpl_id_o        = r_cid;
  assign cpl_cnt_o               = r_cpl_cnt;
  assign ur_cnt_o                = r_ur_cnt;
  assign drop_cnt_o              = r_drop_cnt;

endmodule

// File: tb/tb_pcie_tx_cpl_bfm.sv
// Bench for pcie_tx_cpl_bfm: queue-backed request FIFO, directed scenarios, then randomized
// requests checked against a byte/DW-level reference model of the completion rules.
module tb_pcie_tx_cpl_bfm;
  localparam int MAX_PLD_DW = 256;
  localparam int DT_WD      = 128;
  localparam int HDR_WD     = 128;

  typedef logic [127:0] v_t;
  typedef struct {
    logic [1:0] fmt; logic [4:0] typ; logic [2:0] tc; logic [1:0] attr;
    logic [9:0] len; logic [15:0] rid; logic [3:0] fbe; logic [3:0] lbe;
    logic [31:0] addr; logic [9:0] id;
  } req_t;

  logic core_clk = 1'b0, core_rst;
  logic mrd_rden_o, mrd_rdempty_i, trgtlookup_id_rden_o;
  logic [HDR_WD-1:0] mrd_q_i;
  logic [9:0] trgtlookup_id_i;
  logic [15:0] cpl_id_i;
  logic client0_tlp_hv_o, client0_tlp_dv_o, client0_tlp_eot_o;
  logic [DT_WD-1:0] client0_tlp_data_o;
  logic [3:0] client0_tlp_dwen_o;
  logic [1:0] client0_tlp_fmt_o, client0_tlp_attr_o;
  logic [4:0] client0_tlp_type_o;
  logic [2:0] client0_tlp_tc_o, client0_cpl_status_o;
  logic [12:0] client0_tlp_byte_len_o;
  logic [11:0] client0_cpl_byte_cnt_o;
  logic [6:0] client0_cpl_low_addr_o;
  logic [9:0] client0_cpl_lookup_id_o;
  logic [15:0] client0_req_id_o, client0_cpl_id_o, ur_cnt_o, drop_cnt_o;
  logic xadm_client0_halt_i;
  logic [31:0] cpl_cnt_o;
  logic busy_o;

  int n_tests = 0, n_fail = 0;
  int exp_cpl = 0, exp_ur = 0, exp_drop = 0;
  logic [15:0] exp_cpl_id;
  req_t q4 [4];
  req_t rr;
  bit ok;

  always #5 core_clk = ~core_clk;

  pcie_tx_cpl_bfm #(.MAX_PLD_DW(MAX_PLD_DW), .DT_WD(DT_WD), .HDR_WD(HDR_WD)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .mrd_rden_o(mrd_rden_o), .mrd_q_i(mrd_q_i), .mrd_rdempty_i(mrd_rdempty_i),
    .trgtlookup_id_rden_o(trgtlookup_id_rden_o), .trgtlookup_id_i(trgtlookup_id_i),
    .cpl_id_i(cpl_id_i),
    .client0_tlp_hv_o(client0_tlp_hv_o), .client0_tlp_dv_o(client0_tlp_dv_o),
    .client0_tlp_eot_o(client0_tlp_eot_o), .client0_tlp_data_o(client0_tlp_data_o),
    .client0_tlp_dwen_o(client0_tlp_dwen_o), .client0_tlp_fmt_o(client0_tlp_fmt_o),
    .client0_tlp_type_o(client0_tlp_type_o), .client0_tlp_tc_o(client0_tlp_tc_o),
    .client0_tlp_attr_o(client0_tlp_attr_o), .client0_tlp_byte_len_o(client0_tlp_byte_len_o),
    .client0_cpl_status_o(client0_cpl_status_o), .client0_cpl_byte_cnt_o(client0_cpl_byte_cnt_o),
    .client0_cpl_low_addr_o(client0_cpl_low_addr_o),
    .client0_cpl_lookup_id_o(client0_cpl_lookup_id_o),
    .client0_req_id_o(client0_req_id_o), .client0_cpl_id_o(client0_cpl_id_o),
    .xadm_client0_halt_i(xadm_client0_halt_i),
    .cpl_cnt_o(cpl_cnt_o), .ur_cnt_o(ur_cnt_o), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  // Show-ahead-free FIFO model: popped entry appears on the outputs the cycle after rden.
  logic [127:0] hdr_mem [0:127];
  logic [9:0]   id_mem  [0:127];
  int wr_ptr = 0, rd_ptr = 0;
  assign mrd_rdempty_i = (wr_ptr == rd_ptr);
  always @(posedge core_clk) begin
    if (mrd_rden_o && rd_ptr != wr_ptr) begin
      mrd_q_i         <= hdr_mem[rd_ptr];
      trgtlookup_id_i <= id_mem[rd_ptr];
      rd_ptr          <= rd_ptr + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  function automatic int lo_bit(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction
  function automatic int hi_bit(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) if (b[i]) return i;
    return -1;
  endfunction
  function automatic int len_dw(input req_t r);
    return (r.len == 10'd0) ? 1024 : int'(r.len);
  endfunction
  function automatic bit is_ur(input req_t r);
    return len_dw(r) > MAX_PLD_DW;
  endfunction
  function automatic logic [11:0] exp_bc(input req_t r);
    int bytes;
    if (is_ur(r))             bytes = 0;
    else if (len_dw(r) == 1)  bytes = (r.fbe == 4'd0) ? 1 : hi_bit(r.fbe) - lo_bit(r.fbe) + 1;
    else                      bytes = len_dw(r)*4 - lo_bit(r.fbe) - (3 - hi_bit(r.lbe));
    return 12'(bytes % 4096);
  endfunction
  function automatic logic [127:0] mk_hdr(input req_t r);
    logic [31:0] dw0, dw1;
    dw0 = {1'b0, r.fmt, r.typ, 1'b0, r.tc, 4'b0, 2'b0, r.attr, 2'b0, r.len};
    dw1 = {r.rid, 8'h5A, r.lbe, r.fbe};
    return r.fmt[0] ? {r.addr, 32'h0BAD_F00D, dw1, dw0} : {32'hDEAD_BEEF, r.addr, dw1, dw0};
  endfunction
  function automatic req_t mk_req(input logic [1:0] fmt, input logic [4:0] typ,
      input logic [9:0] len, input logic [31:0] addr, input logic [3:0] fbe,
      input logic [3:0] lbe, input logic [9:0] id, input logic [2:0] tc,
      input logic [1:0] attr, input logic [15:0] rid);
    req_t r;
    r.fmt = fmt; r.typ = typ; r.len = len; r.addr = addr; r.fbe = fbe; r.lbe = lbe;
    r.id = id; r.tc = tc; r.attr = attr; r.rid = rid;
    return r;
  endfunction

  task automatic push(input req_t r);
    hdr_mem[wr_ptr] = mk_hdr(r);
    id_mem[wr_ptr]  = r.id;
    wr_ptr++;
  endtask

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input req_t r, input int b);
    bit ur; int nl, nb, rem; logic [3:0] de; logic [31:0] edw;
    ur = is_ur(r); nl = len_dw(r); nb = ur ? 1 : (nl + 3) / 4; rem = nl % 4;
    if (ur)               de = 4'd0;
    else if (b == nb - 1) de = (rem == 0) ? 4'hF : 4'((1 << rem) - 1);
    else                  de = 4'hF;
    chk("hv", v_t'(client0_tlp_hv_o), v_t'(b == 0));
    chk("dv", v_t'(client0_tlp_dv_o), v_t'(!ur));
    chk("eot", v_t'(client0_tlp_eot_o), v_t'(b == nb - 1));
    chk("dwen", v_t'(client0_tlp_dwen_o), v_t'(de));
    chk("fmt", v_t'(client0_tlp_fmt_o), ur ? v_t'(0) : v_t'(2));
    chk("type", v_t'(client0_tlp_type_o), v_t'(5'b01010));
    chk("tc", v_t'(client0_tlp_tc_o), v_t'(r.tc));
    chk("attr", v_t'(client0_tlp_attr_o), v_t'(r.attr));
    chk("byte_len", v_t'(client0_tlp_byte_len_o), ur ? v_t'(0) : v_t'(nl * 4));
    chk("status", v_t'(client0_cpl_status_o), ur ? v_t'(1) : v_t'(0));
    chk("byte_cnt", v_t'(client0_cpl_byte_cnt_o), v_t'(exp_bc(r)));
    chk("low_addr", v_t'(client0_cpl_low_addr_o), v_t'({r.addr[6:2], 2'(lo_bit(r.fbe))}));
    chk("lookup_id", v_t'(client0_cpl_lookup_id_o), v_t'(r.id));
    chk("req_id", v_t'(client0_req_id_o), v_t'(r.rid));
    chk("cpl_id", v_t'(client0_cpl_id_o), v_t'(exp_cpl_id));
    if (ur) chk("ur_data", v_t'(client0_tlp_data_o), v_t'(0));
    else begin
      for (int j = 0; j < 4; j++) begin
        if (de[j]) begin
          edw = {r.addr[31:2], 2'b00} + 32'(16*b + 4*j);
          chk("data_dw", v_t'(client0_tlp_data_o[j*32 +: 32]), v_t'(edw));
        end
      end
    end
  endtask

  task automatic wait_hv(input int exp_lat, output bit found);
    int n;
    n = 0;
    while (client0_tlp_hv_o !== 1'b1 && n < 40) begin
      @(negedge core_clk);
      n++;
    end
    chk("hv_wait", v_t'(client0_tlp_hv_o), v_t'(1));
    found = (client0_tlp_hv_o === 1'b1);
    if (found && exp_lat > 0) chk("latency", v_t'(n), v_t'(exp_lat));
  endtask

  task automatic chk_counters();
    chk("cpl_cnt", v_t'(cpl_cnt_o), v_t'(exp_cpl));
    chk("ur_cnt", v_t'(ur_cnt_o), v_t'(exp_ur));
    chk("drop_cnt", v_t'(drop_cnt_o), v_t'(exp_drop));
  endtask

  task automatic expect_cpl(input req_t r, input int exp_lat, input int halt_beat,
                            input int halt_n, input bit rnd_halt);
    bit found; int nb, nh;
    wait_hv(exp_lat, found);
    if (!found) return;
    nb = is_ur(r) ? 1 : (len_dw(r) + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      chk_beat(r, b);
      nh = (b == halt_beat) ? halt_n : 0;
      if (rnd_halt && $urandom_range(0, 3) == 0) nh = int'($urandom_range(1, 2));
      repeat (nh) begin
        xadm_client0_halt_i = 1'b1;
        @(negedge core_clk);
        chk_beat(r, b);
      end
      xadm_client0_halt_i = 1'b0;
      @(negedge core_clk);
    end
    exp_cpl++;
    if (is_ur(r)) exp_ur++;
    chk("post_eot_valids", v_t'({client0_tlp_hv_o, client0_tlp_dv_o, client0_tlp_eot_o}), v_t'(0));
    chk_counters();
  endtask

  task automatic expect_drop();
    repeat (8) begin
      @(negedge core_clk);
      chk("drop_quiet", v_t'({client0_tlp_hv_o, client0_tlp_dv_o, client0_tlp_eot_o}), v_t'(0));
    end
    exp_drop++;
    chk("drop_busy", v_t'(busy_o), v_t'(0));
    chk_counters();
  endtask

  initial begin
    core_rst = 1'b1;
    xadm_client0_halt_i = 1'b0;
    cpl_id_i = 16'hBEEF;
    exp_cpl_id = 16'hBEEF;
    repeat (3) @(negedge core_clk);
    chk("rst_valids", v_t'({client0_tlp_hv_o, client0_tlp_dv_o, client0_tlp_eot_o}), v_t'(0));
    chk("rst_data", v_t'(client0_tlp_data_o), v_t'(0));
    chk("rst_rden", v_t'({mrd_rden_o, trgtlookup_id_rden_o, busy_o}), v_t'(0));
    chk_counters();
    core_rst = 1'b0;
    @(negedge core_clk);

    rr = mk_req(2'b00, 5'd0, 10'd1, 32'h1180_0010, 4'hF, 4'h0, 10'h005, 3'd0, 2'd0, 16'h0100);
    push(rr);
    expect_cpl(rr, 3, -1, 0, 1'b0);

    rr = mk_req(2'b00, 5'd0, 10'd6, 32'h1C00_0004, 4'b1110, 4'b0011, 10'h02A, 3'd3, 2'd2, 16'h0200);
    push(rr);
    expect_cpl(rr, 3, -1, 0, 1'b0);
    push(rr);
    expect_cpl(rr, 3, 1, 3, 1'b0);

    rr = mk_req(2'b01, 5'd0, 10'd512, 32'h2000_0040, 4'hF, 4'hF, 10'h033, 3'd1, 2'd1, 16'h0300);
    push(rr);
    expect_cpl(rr, 3, -1, 0, 1'b0);

    rr = mk_req(2'b10, 5'd0, 10'd4, 32'h3000_0000, 4'hF, 4'hF, 10'h044, 3'd0, 2'd0, 16'h0400);
    push(rr);
    expect_drop();

    q4[0] = mk_req(2'b00, 5'd0, 10'd2, 32'h4000_0100, 4'hF, 4'hF, 10'h010, 3'd0, 2'd0, 16'h0500);
    q4[1] = mk_req(2'b01, 5'd0, 10'd8, 32'h4000_0200, 4'hF, 4'hF, 10'h011, 3'd2, 2'd1, 16'h0501);
    q4[2] = mk_req(2'b00, 5'd0, 10'd5, 32'h4000_0304, 4'hC, 4'h1, 10'h012, 3'd4, 2'd3, 16'h0502);
    q4[3] = mk_req(2'b01, 5'd0, 10'd1, 32'h4000_0408, 4'h6, 4'h0, 10'h013, 3'd7, 2'd0, 16'h0503);
    for (int i = 0; i < 4; i++) push(q4[i]);
    expect_cpl(q4[0], 3, -1, 0, 1'b0);
    wait_hv(3, ok);
    chk_beat(q4[1], 0);
    @(negedge core_clk);
    chk_beat(q4[1], 1);
    core_rst = 1'b1;
    @(negedge core_clk);
    core_rst = 1'b0;
    exp_cpl = 0; exp_ur = 0; exp_drop = 0;
    chk("midrst_valids", v_t'({client0_tlp_hv_o, client0_tlp_dv_o, client0_tlp_eot_o}), v_t'(0));
    chk("midrst_data", v_t'(client0_tlp_data_o), v_t'(0));
    chk("midrst_fields", v_t'({client0_cpl_lookup_id_o, client0_tlp_dwen_o, client0_tlp_fmt_o}), v_t'(0));
    chk("midrst_busy", v_t'(busy_o), v_t'(0));
    chk_counters();
    expect_cpl(q4[2], 3, -1, 0, 1'b0);
    expect_cpl(q4[3], 3, -1, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int sel;
      logic [9:0] ln;
      sel = int'($urandom_range(0, 9));
      if (sel == 1)      ln = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(257, 1000));
      else if (sel < 6)  ln = 10'($urandom_range(1, 16));
      else               ln = 10'($urandom_range(1, MAX_PLD_DW));
      rr = mk_req({1'b0, 1'($urandom_range(0, 1))}, 5'd0, ln, $urandom,
                  4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 10'($urandom),
                  3'($urandom), 2'($urandom), 16'($urandom));
      if (ln == 10'd1) begin
        rr.lbe = 4'd0;
        if (sel == 2) rr.fbe = 4'd0;
      end
      if ($urandom_range(0, 3) == 0) begin
        cpl_id_i = 16'($urandom);
        exp_cpl_id = cpl_id_i;
      end
      if (sel == 0) begin
        if ($urandom_range(0, 1) == 0) rr.fmt = {1'b1, 1'($urandom_range(0, 1))};
        else rr.typ = 5'b00100;
        push(rr);
        expect_drop();
      end else begin
        push(rr);
        expect_cpl(rr, 3, -1, 0, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
